// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } serial_sub_state_t;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module fs_bit (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (a - b, LSB first) around one fs_bit cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  serial_sub_state_t state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bin_q, bin_d;
  logic              borrow_q, borrow_d;
  logic              busy_q, done_q;
`ifdef SERIAL_SUB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic fs_d, fs_bout;

  fs_bit u_fs_bit (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .bin_i  (bin_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  // Next-state, datapath shifts and result capture
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = BUSY;
          sa_d     = a;
          sb_d     = b;
          diff_d   = '0;
          cnt_d    = '0;
          bin_d    = 1'b0;
          borrow_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      BUSY: begin
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        // New bit enters at the MSB so the LSB-first stream lands in place
        diff_d = (diff_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
        bin_d  = fs_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = bin_q ^ fs_bout;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= (state_d == BUSY);
      done_q   <= (state_d == DONE);
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
